// File: rtl/cla4_serial_add_ctrl.sv
// cla4_serial_add_ctrl: WIDTH-bit add with carry-in, one nibble per pass through a shared 4-bit CLA.
// Rev 1.0 -- optional carry-pass counter enabled by CLA_SEQ_CARRY_STATS_EN.
`default_nettype none

module cla4_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_cin,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy,
  output logic [3:0]       o_add1,
  output logic [3:0]       o_add2,
  input  logic [4:0]       i_add_result
`ifdef CLA_SEQ_CARRY_STATS_EN
  ,
  output logic [$clog2(WIDTH/4+1)-1:0] o_carry_passes
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int PW      = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_CARRY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       tmp_q, tmp_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]    passes_q, passes_d;
  logic             adv;
  logic             last_nib;

  function automatic logic [WIDTH-1:0] put_nib(input logic [WIDTH-1:0] v,
                                               input logic [3:0]       n,
                                               input logic [KW-1:0]    k);
    put_nib = (v & ~(WIDTH'(4'hF) << {k, 2'b00})) | (WIDTH'(n) << {k, 2'b00});
  endfunction

  assign last_nib    = (k_q == KW'(NIBBLES - 1));
  assign o_req_ready = (state_q == S_IDLE) && i_rst_n;
  assign o_busy      = (state_q == S_ADD) || (state_q == S_CARRY);
  assign o_sum       = sum_q;
  assign o_cout      = cout_q;
  assign o_rsp_valid = rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cr_d        = cr_q;
    a_d         = a_q;
    b_d         = b_q;
    tmp_d       = tmp_q;
    tc_d        = tc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
    passes_d    = passes_q;
    adv         = 1'b0;
    o_add1      = 4'd0;
    o_add2      = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          a_d      = i_op_a;
          b_d      = i_op_b;
          cr_d     = i_cin;
          k_d      = '0;
          sum_d    = '0;
          passes_d = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        o_add1 = 4'(a_q >> {k_q, 2'b00});
        o_add2 = 4'(b_q >> {k_q, 2'b00});
        if (!cr_q) begin
          sum_d = put_nib(sum_q, i_add_result[3:0], k_q);
          cr_d  = i_add_result[4];
          adv   = 1'b1;
        end else begin
          // The adder has no carry-in, so a pending carry costs a second "+1" pass.
          tmp_d   = i_add_result[3:0];
          tc_d    = i_add_result[4];
          state_d = S_CARRY;
        end
      end
      S_CARRY: begin
        o_add1   = tmp_q;
        o_add2   = 4'b0001;
        sum_d    = put_nib(sum_q, i_add_result[3:0], k_q);
        cr_d     = tc_q | i_add_result[4];
        passes_d = passes_q + PW'(1);
        adv      = 1'b1;
      end
      S_DONE: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (last_nib) begin
        cout_d      = cr_d;
        rsp_valid_d = 1'b1;
        state_d     = S_DONE;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = S_ADD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cr_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tmp_q       <= 4'd0;
      tc_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      passes_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cr_q        <= cr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tmp_q       <= tmp_d;
      tc_q        <= tc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
      passes_q    <= passes_d;
    end
  end

`ifdef CLA_SEQ_CARRY_STATS_EN
  assign o_carry_passes = passes_q;
`else
  logic unused_passes;
  assign unused_passes = ^passes_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla4_serial_add_ctrl.sv
// tb_cla4_serial_add_ctrl: directed vector table plus reset/backpressure sequences and random ops.
`default_nettype none

module tb_cla4_serial_add_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         i_cin;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_busy;
  logic [3:0]   o_add1;
  logic [3:0]   o_add2;
  logic [4:0]   i_add_result;
`ifdef CLA_SEQ_CARRY_STATS_EN
  logic [$clog2(N+1)-1:0] o_carry_passes;
`endif

  always #5 i_clk = ~i_clk;

  // external 4-bit carry lookahead adder, no carry-in
  assign i_add_result = {1'b0, o_add1} + {1'b0, o_add2};

  cla4_serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_op_a       (i_op_a),
    .i_op_b       (i_op_b),
    .i_cin        (i_cin),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_sum        (o_sum),
    .o_cout       (o_cout),
    .o_busy       (o_busy),
    .o_add1       (o_add1),
    .o_add2       (o_add2),
    .i_add_result (i_add_result)
`ifdef CLA_SEQ_CARRY_STATS_EN
    ,
    .o_carry_passes (o_carry_passes)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    int           lat;
  } vec_t;

  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic       cr;
    logic [4:0] t;
    int         p;
    cr = cin;
    p  = 0;
    for (int i = 0; i < N; i++) begin
      if (cr) p++;
      t  = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, cr};
      cr = t[4];
    end
    return N + p;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input int el, input int hold);
    int lat;
    @(negedge i_clk);
    chk("ready_idle", 32'(o_req_ready), 32'd1);
    i_op_a      = a;
    i_op_b      = b;
    i_cin       = cin;
    i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_op_a      = ~a;
    i_op_b      = ~b;
    i_cin       = ~cin;
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    chk("add1_nib0", 32'(o_add1), 32'(a[3:0]));
    chk("add2_nib0", 32'(o_add2), 32'(b[3:0]));
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    chk("rsp_valid_seen", 32'(o_rsp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(el));
    chk("sum", 32'(o_sum), 32'(es));
    chk("cout", 32'(o_cout), 32'(ec));
    chk("busy_done", 32'(o_busy), 32'd0);
`ifdef CLA_SEQ_CARRY_STATS_EN
    chk("carry_passes", 32'(o_carry_passes), 32'(el - N));
`endif
    for (int h = 0; h < hold; h++) begin
      i_req_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_sum", 32'(o_sum), 32'(es));
      chk("hold_ready", 32'(o_req_ready), 32'd0);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(o_rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rt;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 6};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 7};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 5};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 8};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4};
    vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 8};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 4};

    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    i_op_a      = '0;
    i_op_b      = '0;
    i_cin       = 1'b0;
    @(negedge i_clk);
    chk("ready_in_reset", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_cout", 32'(o_cout), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_add1", 32'(o_add1), 32'd0);
    chk("rst_add2", 32'(o_add2), 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].lat, (i == 1) ? 5 : 0);

    // reset while in CARRY: 0+0 with cin=1 reaches CARRY two edges after accept
    @(negedge i_clk);
    i_op_a      = 16'h0000;
    i_op_b      = 16'h0000;
    i_cin       = 1'b1;
    i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("carry_busy", 32'(o_busy), 32'd1);
    chk("carry_add1", 32'(o_add1), 32'd0);
    chk("carry_add2", 32'(o_add2), 32'd1);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_add", 32'({o_add1, o_add2}), 32'd0);
    chk("midrst_sum", 32'({o_cout, o_sum}), 32'd0);
    chk("midrst_ready", 32'(o_req_ready), 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("postrst_no_rsp", 32'(o_rsp_valid), 32'd0);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rt = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, rt[W-1:0], rt[W], model_lat(ra, rb, rc), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
